// File: rtl/jt51_mixacc_if.sv
// Slot/sample bus of the jt51_mixacc frame mixer.
// master: slot sequencer side (drives slot data, clip_clr, ch_rd).
// slave : the mixer itself.
// Parameters must match those of the jt51_mixacc instance on the bus.
interface jt51_mixacc_if #(
   parameter int CH   = 8,
   parameter int OPW  = 14,
   parameter int NW   = 11,
   parameter int OUTW = 16
);
   localparam int SW = (CH > 1) ? $clog2(CH) : 1;

   logic                   clk_en;
   logic                   frame_end;
   logic [SW-1:0]          slot_ch;
   logic                   carrier;
   logic [1:0]             rl;
   logic signed [OPW-1:0]  op_out;
   logic                   ne;
   logic                   noise_slot;
   logic signed [NW-1:0]   noise;
   logic                   clip_clr;
   logic [SW-1:0]          ch_rd;
   logic signed [OUTW-1:0] left;
   logic signed [OUTW-1:0] right;
   logic                   sample_valid;
   logic                   clip;
   logic signed [OUTW-1:0] ch_out;

   modport master (
      output clk_en, frame_end, slot_ch, carrier, rl, op_out,
             ne, noise_slot, noise, clip_clr, ch_rd,
      input  left, right, sample_valid, clip, ch_out
   );

   modport slave (
      input  clk_en, frame_end, slot_ch, carrier, rl, op_out,
             ne, noise_slot, noise, clip_clr, ch_rd,
      output left, right, sample_valid, clip, ch_out
   );
endinterface

// File: rtl/jt51_mixacc.sv
// jt51_mixacc: per-frame stereo mixer of FM carrier slots.
// Each enabled carrier slot adds its operator (or noise) sample into the
// left/right accumulators according to pan; frame_end publishes the sums
// on left/right with a one-clk sample_valid pulse and restarts the frame.
// Sums saturate (SAT=1) or wrap (SAT=0); any overflow sets the sticky clip.
// Optional feature macro: JT51_MIXACC_CHOUT_EN adds pre-pan per-channel
// accumulators, a frame bank and a registered read port (ch_rd -> ch_out).
module jt51_mixacc #(
   parameter int CH   = 8,
   parameter int OPW  = 14,
   parameter int NW   = 11,
   parameter int OUTW = 16,
   parameter int SAT  = 1
) (
   input logic         clk,
   input logic         rst,
   jt51_mixacc_if.slave bus
);
   localparam int SW = (CH > 1) ? $clog2(CH) : 1;

   typedef logic signed [OUTW-1:0] acc_t;
   typedef logic signed [OPW-1:0]  op_t;

   localparam acc_t ACC_MAX = {1'b0, {(OUTW-1){1'b1}}};
   localparam acc_t ACC_MIN = {1'b1, {(OUTW-1){1'b0}}};

   // Widen to OUTW+1 bits; the two top bits disagree exactly on overflow.
   function automatic acc_t add_sat(input acc_t a, input op_t b, output logic ovf);
      logic signed [OUTW:0] s;
      s   = (OUTW+1)'(a) + (OUTW+1)'(b);
      ovf = s[OUTW] ^ s[OUTW-1];
      if (ovf && SAT != 0) return s[OUTW] ? ACC_MIN : ACC_MAX;
      return s[OUTW-1:0];
   endfunction

   acc_t acc_l, acc_r, left_q, right_q;
   logic sample_valid_q, clip_q;

   // Noise replaces the operator sample: sign-extend to OPW-1 bits, x2.
   logic signed [OPW-2:0] noise_ext;
   op_t                   op_val;
   assign noise_ext = (OPW-1)'(bus.noise);
   assign op_val    = (bus.ne && bus.noise_slot) ? {noise_ext, 1'b0} : bus.op_out;

   // A slot channel index beyond CH is ignored; no compare needed when CH fills SW bits.
   logic slot_ok;
   generate
      if (CH == (1 << SW)) begin : g_slot_full
         assign slot_ok = 1'b1;
      end else begin : g_slot_cmp
         assign slot_ok = (bus.slot_ch < SW'(CH));
      end
   endgenerate

   logic take;
   assign take = bus.clk_en && bus.carrier && slot_ok;

   // Next accumulator values including this slot's panned contribution.
   acc_t sum_l, sum_r, nxt_l, nxt_r;
   logic ovf_l, ovf_r, ovf_pan;
   always_comb begin
      // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
      ovf_l   = 1'b0;
      ovf_r   = 1'b0;
      sum_l   = add_sat(acc_l, op_val, ovf_l);
      sum_r   = add_sat(acc_r, op_val, ovf_r);
      nxt_l   = (take && bus.rl[0]) ? sum_l : acc_l;
      nxt_r   = (take && bus.rl[1]) ? sum_r : acc_r;
      ovf_pan = take && ((bus.rl[0] && ovf_l) || (bus.rl[1] && ovf_r));
   end

   logic ovf_ch;

`ifdef JT51_MIXACC_CHOUT_EN
   acc_t ch_acc  [CH];
   acc_t ch_bank [CH];
   acc_t ch_q;
   acc_t sum_c;
   logic ovf_c;
   logic rd_ok;

   generate
      if (CH == (1 << SW)) begin : g_rd_full
         assign rd_ok = 1'b1;
      end else begin : g_rd_cmp
         assign rd_ok = (bus.ch_rd < SW'(CH));
      end
   endgenerate

   // Pre-pan per-channel sum for the slot's channel.
   always_comb begin
      ovf_c = 1'b0;
      sum_c = add_sat(ch_acc[bus.slot_ch], op_val, ovf_c);
   end

   assign ovf_ch = take && ovf_c;

   // Per-channel accumulate, frame bank copy, and registered read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the channel arrays are reset explicitly because a reset must discard the frame; plain storage arrays would normally not be reset.
         for (int i = 0; i < CH; i++) begin
            ch_acc[i]  <= '0;
            ch_bank[i] <= '0;
         end
         ch_q <= '0;
      end else begin
         ch_q <= rd_ok ? ch_bank[bus.ch_rd] : '0;
         if (bus.clk_en && bus.frame_end) begin
            for (int i = 0; i < CH; i++) begin
               ch_bank[i] <= (take && bus.slot_ch == SW'(i)) ? sum_c : ch_acc[i];
               ch_acc[i]  <= '0;
            end
         end else if (take) begin
            ch_acc[bus.slot_ch] <= sum_c;
         end
      end
   end

   assign bus.ch_out = ch_q;
`else
   logic unused_ch_inputs;
   assign unused_ch_inputs = ^{bus.ch_rd, bus.slot_ch};
   assign ovf_ch           = 1'b0;
   assign bus.ch_out       = '0;
`endif

   // Frame accumulation, sample publication and sticky clip.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_l          <= '0;
         acc_r          <= '0;
         left_q         <= '0;
         right_q        <= '0;
         sample_valid_q <= 1'b0;
         clip_q         <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         sample_valid_q <= 1'b0;
         if (bus.clk_en) begin
            if (bus.frame_end) begin
               left_q         <= nxt_l;
               right_q        <= nxt_r;
               acc_l          <= '0;
               acc_r          <= '0;
               sample_valid_q <= 1'b1;
            end else begin
               acc_l <= nxt_l;
               acc_r <= nxt_r;
            end
         end
         if (ovf_pan || ovf_ch) clip_q <= 1'b1;
         else if (bus.clip_clr) clip_q <= 1'b0;
      end
   end

   assign bus.left         = left_q;
   assign bus.right        = right_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.clip         = clip_q;
endmodule

// File: tb/tb_jt51_mixacc.sv
// Bench for jt51_mixacc: two instances (SAT=1 and SAT=0) share one stimulus
// stream. A reference model of frame sums, clip and the channel bank pushes
// expected frames into a scoreboard; a negedge monitor pops and compares.
module tb_jt51_mixacc;
   localparam longint MAXV = 32767;
   localparam longint MINV = -32768;
   localparam int     NCH  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jt51_mixacc_if if0 ();
   jt51_mixacc_if if1 ();

   jt51_mixacc #(.SAT(1)) u_sat  (.clk(clk), .rst(rst), .bus(if0.slave));
   jt51_mixacc #(.SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(if1.slave));

   typedef struct {
      bit       ce, fe, car, ne, ns, cc;
      int       ch, op, nz, rd;
      bit [1:0] rl;
   } stim_t;

   typedef struct { longint l0, r0, l1, r1; } frame_t;

   int     n_cmp = 0;
   int     n_bad = 0;
   bit     mon_en = 1'b0;
   frame_t sbq[$];
   frame_t hold;
   longint ml[2], mr[2], exp_ch[2];
   longint mch[2][NCH], mbank[2][NCH];
   bit     mclip[2];

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Add with either clamp or modulo-2^16 wrap; flags out-of-range sums.
   function automatic longint madd(input longint a, input longint v, input bit sat, inout bit ovf);
      longint s;
      s = a + v;
      if (s > MAXV || s < MINV) begin
         ovf = 1'b1;
         if (sat) s = (s > MAXV) ? MAXV : MINV;
         else     s = ((s + 32768) % 65536 + 65536) % 65536 - 32768;
      end
      return s;
   endfunction

   // Reference behaviour for one clock edge.
   task automatic model_edge(input stim_t s);
      if (rst) begin
         sbq.delete();
         hold = '{0, 0, 0, 0};
         for (int d = 0; d < 2; d++) begin
            ml[d] = 0; mr[d] = 0; exp_ch[d] = 0; mclip[d] = 1'b0;
            for (int c = 0; c < NCH; c++) begin mch[d][c] = 0; mbank[d][c] = 0; end
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            bit     ovf;
            longint v;
            ovf = 1'b0;
`ifdef JT51_MIXACC_CHOUT_EN
            exp_ch[d] = (s.rd < NCH) ? mbank[d][s.rd] : 0;
`else
            exp_ch[d] = 0;
`endif
            v = (s.ne && s.ns) ? longint'(s.nz) * 2 : longint'(s.op);
            if (s.ce && s.car && s.ch < NCH) begin
               if (s.rl[0]) ml[d] = madd(ml[d], v, d == 0, ovf);
               if (s.rl[1]) mr[d] = madd(mr[d], v, d == 0, ovf);
`ifdef JT51_MIXACC_CHOUT_EN
               mch[d][s.ch] = madd(mch[d][s.ch], v, d == 0, ovf);
`endif
            end
            if (ovf) mclip[d] = 1'b1;
            else if (s.cc) mclip[d] = 1'b0;
         end
         if (s.ce && s.fe) begin
            sbq.push_back('{ml[0], mr[0], ml[1], mr[1]});
            for (int d = 0; d < 2; d++) begin
               ml[d] = 0; mr[d] = 0;
               for (int c = 0; c < NCH; c++) begin
                  mbank[d][c] = mch[d][c];
                  mch[d][c]   = 0;
               end
            end
         end
      end
   endtask

   task automatic drive(input stim_t s);
      if0.clk_en = s.ce;      if1.clk_en = s.ce;
      if0.frame_end = s.fe;   if1.frame_end = s.fe;
      if0.slot_ch = 3'(s.ch); if1.slot_ch = 3'(s.ch);
      if0.carrier = s.car;    if1.carrier = s.car;
      if0.rl = s.rl;          if1.rl = s.rl;
      if0.op_out = 14'(s.op); if1.op_out = 14'(s.op);
      if0.ne = s.ne;          if1.ne = s.ne;
      if0.noise_slot = s.ns;  if1.noise_slot = s.ns;
      if0.noise = 11'(s.nz);  if1.noise = 11'(s.nz);
      if0.clip_clr = s.cc;    if1.clip_clr = s.cc;
      if0.ch_rd = 3'(s.rd);   if1.ch_rd = 3'(s.rd);
   endtask

   // Apply one slot for one clock; returns at the following negedge.
   task automatic step(input stim_t s);
      drive(s);
      @(posedge clk);
      model_edge(s);
      @(negedge clk);
   endtask

   function automatic stim_t idle_s();
      stim_t s;
      s = '{ce: 1'b0, fe: 1'b0, car: 1'b0, ne: 1'b0, ns: 1'b0, cc: 1'b0,
            ch: 0, op: 0, nz: 0, rd: 0, rl: 2'b00};
      return s;
   endfunction

   task automatic slot(input int ch, input bit [1:0] rl, input int op, input bit fe);
      stim_t s;
      s = idle_s();
      s.ce = 1'b1; s.car = 1'b1; s.ch = ch; s.rl = rl; s.op = op; s.fe = fe;
      step(s);
   endtask

   // Scoreboard monitor: a pending frame means sample_valid is due now.
   always @(negedge clk) begin
      if (mon_en) begin
         bit exp_sv;
         exp_sv = (sbq.size() != 0);
         check("sample_valid_sat",  if0.sample_valid, exp_sv);
         check("sample_valid_wrap", if1.sample_valid, exp_sv);
         if (exp_sv) hold = sbq.pop_front();
         check("left_sat",   if0.left,  hold.l0);
         check("right_sat",  if0.right, hold.r0);
         check("left_wrap",  if1.left,  hold.l1);
         check("right_wrap", if1.right, hold.r1);
         check("clip_sat",   if0.clip,  mclip[0]);
         check("clip_wrap",  if1.clip,  mclip[1]);
         check("ch_out_sat",  if0.ch_out, exp_ch[0]);
         check("ch_out_wrap", if1.ch_out, exp_ch[1]);
      end
   end

   initial begin
      stim_t s;
      // Reset
      rst = 1'b1;
      step(idle_s());
      mon_en = 1'b1;
      step(idle_s());
      rst = 1'b0;
      step(idle_s());

      // Four equal carriers, both sides
      for (int i = 0; i < 4; i++) slot(i, 2'b11, 1000, i == 3);
      check("basic_left",  if0.left,  4000);
      check("basic_right", if0.right, 4000);
      check("basic_valid", if0.sample_valid, 1);
      step(idle_s());
      check("basic_valid_drop", if0.sample_valid, 0);

      // Positive overflow, left only
      for (int i = 0; i < 5; i++) slot(i, 2'b01, 8191, i == 4);
      check("ovf_left_sat",   if0.left,  32767);
      check("ovf_right_sat",  if0.right, 0);
      check("ovf_left_wrap",  if1.left,  -24581);
      check("ovf_clip_sat",   if0.clip,  1);
      check("ovf_clip_wrap",  if1.clip,  1);
      s = idle_s(); s.cc = 1'b1;
      step(s);
      check("clip_cleared", if0.clip, 0);

      // Noise replaces operator sample, right only
      s = idle_s();
      s.ce = 1'b1; s.car = 1'b1; s.fe = 1'b1; s.rl = 2'b10;
      s.op = 5000; s.ne = 1'b1; s.ns = 1'b1; s.nz = -1024;
      step(s);
      check("noise_right", if0.right, -2048);
      check("noise_left",  if0.left,  0);

      // Reset mid-frame discards the partial sum; clk_en=0 slots are ignored
      slot(1, 2'b11, 3000, 1'b0);
      rst = 1'b1;
      step(idle_s());
      rst = 1'b0;
      slot(1, 2'b11, 200, 1'b0);
      s = idle_s(); s.car = 1'b1; s.rl = 2'b11; s.op = 777; s.ch = 2;
      step(s);
      s.fe = 1'b1;
      step(s);
      check("rst_hold_left", if0.left, 0);
      s = idle_s(); s.ce = 1'b1; s.fe = 1'b1;
      step(s);
      check("rst_left",  if0.left,  200);
      check("rst_right", if0.right, 200);

      // Per-channel sums
      slot(2, 2'b01, 100, 1'b0);
      slot(5, 2'b10, -50, 1'b0);
      slot(2, 2'b00, 300, 1'b1);
      s = idle_s(); s.rd = 2;
      step(s);
`ifdef JT51_MIXACC_CHOUT_EN
      check("chout_2", if0.ch_out, 400);
`else
      check("chout_off", if0.ch_out, 0);
`endif
      s.rd = 5;
      step(s);
`ifdef JT51_MIXACC_CHOUT_EN
      check("chout_5", if0.ch_out, -50);
`endif

      // Overflow with simultaneous clip_clr: set wins
      for (int i = 0; i < 4; i++) slot(i, 2'b01, 8191, 1'b0);
      s = idle_s();
      s.ce = 1'b1; s.car = 1'b1; s.rl = 2'b01; s.op = 8191; s.cc = 1'b1;
      step(s);
      check("clip_set_wins", if0.clip, 1);
      s = idle_s(); s.cc = 1'b1;
      step(s);
      check("clip_clr_alone", if0.clip, 0);
      s = idle_s(); s.ce = 1'b1; s.fe = 1'b1;
      step(s);

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         s.ce  = ($urandom_range(0, 3) != 0);
         s.fe  = ($urandom_range(0, 7) == 0);
         s.car = ($urandom_range(0, 4) != 0);
         s.ch  = $urandom_range(0, NCH - 1);
         s.rl  = 2'($urandom_range(0, 3));
         s.op  = int'($urandom_range(0, 16383)) - 8192;
         s.ne  = ($urandom_range(0, 3) == 0);
         s.ns  = ($urandom_range(0, 1) == 0);
         s.nz  = int'($urandom_range(0, 2047)) - 1024;
         s.cc  = ($urandom_range(0, 15) == 0);
         s.rd  = $urandom_range(0, NCH - 1);
         rst   = ($urandom_range(0, 199) == 0);
         step(s);
      end
      rst = 1'b0;
      step(idle_s());
      step(idle_s());
      check("scoreboard_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
